snes_port_reader: RTL
=====================

SNES_PORT_READER -- requirements
Module: snes_port_reader

Interface
REQ-001 Parameter HALF, default 8: length in CLK cycles of every half bit-period; legal range 4..255.
REQ-002 CLK  input  1  system clock; all logic on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 START  input  1  one-cycle request to begin one read transaction.
REQ-005 PORT_DO  input  2  serial data from the two port devices, active-low: bit0 = port 1, bit1 = port 2.
REQ-006 PORT_P6  input  1  asynchronous, active-low lightgun/IO strobe from port 2.
REQ-007 HCNT, VCNT  input  9 each  current PPU pixel and line counters.
REQ-008 P6_EN  input  1  enables counter latching from PORT_P6.
REQ-009 CLR_LATCHED  input  1  one-cycle clear of LATCHED.
REQ-010 PORT_LATCH  output  1  latch strobe to both ports, active-high.
REQ-011 PORT_CLK  output  1  shift clock to both ports; idles high.
REQ-012 JOY1, JOY2  output  16 each  decoded button words, active-high.
REQ-013 BUSY  output  1  high while a transaction runs.
REQ-014 DONE  output  1  one-cycle pulse when JOY1/JOY2 update.
REQ-015 OPHCT, OPVCT  output  9 each  counter values captured on a P6 strobe.
REQ-016 LATCHED  output  1  a capture has occurred since the last clear.

Function
REQ-017 PORT_DO and PORT_P6 shall each pass through a 2-flop synchronizer before any use.
REQ-018 The FSM shall have states IDLE, LATCH, GAP, CLKLO, CLKHI, plus a 4-bit bit counter and an 8-bit tick counter.
REQ-019 IDLE: START=1 -> LATCH on the next cycle with BUSY=1; START shall be ignored in every other state.
REQ-020 LATCH: PORT_LATCH=1 for exactly 2*HALF cycles, then GAP.
REQ-021 GAP: PORT_LATCH=0, PORT_CLK=1 for HALF cycles, then CLKLO with bit counter = 0.
REQ-022 CLKLO: PORT_CLK=0 for HALF cycles; on its last cycle sample the inverted synchronized PORT_DO bits into shift registers, then CLKHI.
REQ-023 CLKHI: PORT_CLK=1 for HALF cycles; then bit counter < 15 -> increment and go to CLKLO, bit counter = 15 -> IDLE.
REQ-024 Each transaction shall produce exactly 16 PORT_CLK rising edges.
REQ-025 Bit order: first sampled bit -> JOY[15], sixteenth -> JOY[0] (shift left, new bit at LSB).
REQ-026 JOY1/JOY2 shall update atomically on the CLKHI->IDLE transition, with DONE=1 and BUSY=0 in that same cycle; JOY outputs shall hold unchanged at all other times.
REQ-027 Total transaction length: 2*HALF + HALF + 32*HALF = 35*HALF cycles from the first LATCH cycle to DONE inclusive.
REQ-028 PORT_CLK and PORT_LATCH shall be registered and glitch-free, and shall never both be active-changing in the same cycle.
REQ-029 Capture: synchronized P6 falling edge with P6_EN=1 and LATCHED=0 -> OPHCT<=HCNT, OPVCT<=VCNT, LATCHED<=1 on the next cycle.
REQ-030 A P6 falling edge while LATCHED=1 or P6_EN=0 shall be ignored; OPHCT/OPVCT shall hold.
REQ-031 CLR_LATCHED coinciding with a capturing edge: the capture wins (LATCHED=1, new values).
REQ-032 Capture logic shall run independently of the transaction FSM.

Reset
REQ-033 RESET in any state, including mid-transaction, shall force on the next edge: FSM=IDLE, PORT_LATCH=0, PORT_CLK=1, BUSY=0, DONE=0, JOY1=JOY2=0, OPHCT=OPVCT=0, LATCHED=0, counters=0, synchronizers=1 (idle high).
REQ-034 A partially shifted word shall never reach JOY1/JOY2 after reset.

Verification
REQ-035 HALF=4, device model returns ~16'h8001 on port 1 and ~16'h1234 on port 2, START pulse -> PORT_LATCH high 8 cycles, 16 PORT_CLK rising edges, DONE 140 cycles after LATCH start, JOY1=16'h8001, JOY2=16'h1234.
REQ-036 START pulsed again at cycle 50 of a transaction -> ignored, a single DONE, exactly 16 clock edges.
REQ-037 RESET asserted during CLKLO of bit 7 -> next cycle PORT_CLK=1, BUSY=0, JOY1=JOY2=0, no DONE.
REQ-038 P6_EN=1, P6 low pulse while HCNT=9'd100, VCNT=9'd50 -> after synchronizer latency OPHCT=100, OPVCT=50, LATCHED=1; a second pulse at HCNT=200 leaves OPHCT=100.
REQ-039 CLR_LATCHED then P6 pulse with P6_EN=0 -> LATCHED stays 0; with P6_EN=1 and CLR_LATCHED coinciding with the edge -> LATCHED=1.
REQ-040 Back-to-back START on the DONE cycle+1 -> a second transaction begins at once, and JOY outputs change only at the second DONE.

Source files
------------

// File: rtl/snes_port_reader_if.sv
// snes_port_reader_if
//   Signal bundle between a host and snes_port_reader, including the
//   port-side pins (PORT_*) and the PPU counter capture path.
//
//   Handshake: START is a single-cycle request, accepted only while BUSY=0.
//   BUSY rises the cycle after an accepted START and falls in the same cycle
//   that DONE pulses for one cycle. JOY1/JOY2 are valid from that DONE cycle
//   and hold until the next DONE. START is ignored while BUSY=1.
//
//   master : host side (drives START, port inputs, counters, capture controls)
//   slave  : reader side (drives port strobes, button words, status, captures)
interface snes_port_reader_if;
  logic        START;
  logic [1:0]  PORT_DO;
  logic        PORT_P6;
  logic [8:0]  HCNT;
  logic [8:0]  VCNT;
  logic        P6_EN;
  logic        CLR_LATCHED;
  logic        PORT_LATCH;
  logic        PORT_CLK;
  logic [15:0] JOY1;
  logic [15:0] JOY2;
  logic        BUSY;
  logic        DONE;
  logic [8:0]  OPHCT;
  logic [8:0]  OPVCT;
  logic        LATCHED;
  logic [2:0]  DBG_STATE;

  modport master (
    output START, PORT_DO, PORT_P6, HCNT, VCNT, P6_EN, CLR_LATCHED,
    input  PORT_LATCH, PORT_CLK, JOY1, JOY2, BUSY, DONE,
           OPHCT, OPVCT, LATCHED, DBG_STATE
  );

  modport slave (
    input  START, PORT_DO, PORT_P6, HCNT, VCNT, P6_EN, CLR_LATCHED,
    output PORT_LATCH, PORT_CLK, JOY1, JOY2, BUSY, DONE,
           OPHCT, OPVCT, LATCHED, DBG_STATE
  );
endinterface

// File: rtl/snes_port_reader.sv
// snes_port_reader
//   Reads both SNES controller ports serially: a latch strobe of 2*HALF
//   cycles, a HALF-cycle gap, then 16 clock periods (HALF low, HALF high).
//   Data is sampled on the last cycle of each low phase and shifted in MSB
//   first, so the first bit lands in JOY[15]. Button words update together
//   on DONE. Independently, a falling edge on PORT_P6 (lightgun/IO strobe)
//   captures HCNT/VCNT once until LATCHED is cleared.
//
// Ports
//   CLK    : system clock, rising edge
//   RESET  : synchronous, active-high
//   bus    : snes_port_reader_if.slave (see interface for signal list)
// Parameter
//   HALF   : cycles per half bit-period, legal 4..255
module snes_port_reader #(
  parameter int unsigned HALF = 8
) (
  input logic             CLK,
  input logic             RESET,
  snes_port_reader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_GAP   = 3'd2,
    S_CLKLO = 3'd3,
    S_CLKHI = 3'd4
  } state_t;

  localparam logic [7:0] TICK_LAST = 8'(HALF - 1);

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [7:0]  tick;
  logic [15:0] sh1;
  logic [15:0] sh2;

  logic [1:0]  do_s1;
  logic [1:0]  do_s2;
  logic        p6_s1;
  logic        p6_s2;
  logic        p6_prev;
  logic        p6_fall;
  logic        tick_done;

  assign tick_done     = (tick == TICK_LAST);
  assign p6_fall       = p6_prev & ~p6_s2;
  assign bus.DBG_STATE = state;

  // Transaction FSM. The latch phase is 2*HALF long, which can exceed the
  // 8-bit tick range, so it is timed as two HALF periods with bit_cnt[0]
  // marking the second one.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= S_IDLE;
      bit_cnt        <= 4'd0;
      tick           <= 8'd0;
      sh1            <= 16'd0;
      sh2            <= 16'd0;
      bus.PORT_LATCH <= 1'b0;
      bus.PORT_CLK   <= 1'b1;
      bus.BUSY       <= 1'b0;
      bus.DONE       <= 1'b0;
      bus.JOY1       <= 16'd0;
      bus.JOY2       <= 16'd0;
    end else begin
      bus.DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          tick    <= 8'd0;
          bit_cnt <= 4'd0;
          if (bus.START) begin
            state          <= S_LATCH;
            bus.BUSY       <= 1'b1;
            bus.PORT_LATCH <= 1'b1;
          end
        end
        S_LATCH: begin
          if (tick_done) begin
            tick <= 8'd0;
            if (bit_cnt[0]) begin
              bit_cnt        <= 4'd0;
              state          <= S_GAP;
              bus.PORT_LATCH <= 1'b0;
            end else begin
              bit_cnt <= 4'd1;
            end
          end else begin
            tick <= tick + 8'd1;
          end
        end
        S_GAP: begin
          if (tick_done) begin
            tick         <= 8'd0;
            bit_cnt      <= 4'd0;
            state        <= S_CLKLO;
            bus.PORT_CLK <= 1'b0;
          end else begin
            tick <= tick + 8'd1;
          end
        end
        S_CLKLO: begin
          if (tick_done) begin
            tick         <= 8'd0;
            // Port data is active-low; store pressed buttons as 1.
            sh1          <= {sh1[14:0], ~do_s2[0]};
            sh2          <= {sh2[14:0], ~do_s2[1]};
            state        <= S_CLKHI;
            bus.PORT_CLK <= 1'b1;
          end else begin
            tick <= tick + 8'd1;
          end
        end
        S_CLKHI: begin
          if (tick_done) begin
            tick <= 8'd0;
            if (bit_cnt == 4'd15) begin
              bit_cnt  <= 4'd0;
              state    <= S_IDLE;
              bus.JOY1 <= sh1;
              bus.JOY2 <= sh2;
              bus.DONE <= 1'b1;
              bus.BUSY <= 1'b0;
            end else begin
              bit_cnt      <= bit_cnt + 4'd1;
              state        <= S_CLKLO;
              bus.PORT_CLK <= 1'b0;
            end
          end else begin
            tick <= tick + 8'd1;
          end
        end
        default: begin
          state          <= S_IDLE;
          tick           <= 8'd0;
          bit_cnt        <= 4'd0;
          bus.PORT_LATCH <= 1'b0;
          bus.PORT_CLK   <= 1'b1;
          bus.BUSY       <= 1'b0;
        end
      endcase
    end
  end

  // Input synchronizers and the P6 counter capture; idle level of every
  // port line is high, so the flops reset to 1 to avoid a false edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      do_s1       <= 2'b11;
      do_s2       <= 2'b11;
      p6_s1       <= 1'b1;
      p6_s2       <= 1'b1;
      p6_prev     <= 1'b1;
      bus.OPHCT   <= 9'd0;
      bus.OPVCT   <= 9'd0;
      bus.LATCHED <= 1'b0;
    end else begin
      do_s1   <= bus.PORT_DO;
      do_s2   <= do_s1;
      p6_s1   <= bus.PORT_P6;
      p6_s2   <= p6_s1;
      p6_prev <= p6_s2;
      // A capture takes priority over a simultaneous clear.
      if (p6_fall && bus.P6_EN && !bus.LATCHED) begin
        bus.OPHCT   <= bus.HCNT;
        bus.OPVCT   <= bus.VCNT;
        bus.LATCHED <= 1'b1;
      end else if (bus.CLR_LATCHED) begin
        bus.LATCHED <= 1'b0;
      end
    end
  end

endmodule
